// File: rtl/queen_stack.sv
// LIFO of queen column positions, one entry per board row; each push/pop takes two cycles (capture, commit).
// Backpressure: stack_ready drops for the commit cycle and requests seen then are dropped, not queued.
module queen_stack #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 3,
    localparam int DW    = $clog2(DEPTH) + 1,
    localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             enable_output,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             stack_ready,
    output logic             underflow,
    output logic             overflow,
    output logic             out_valid,
    output logic [RW-1:0]    out_row,
    output logic [WIDTH-1:0] out_column
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic             op_push_q, op_push_d;
    logic             op_en_q, op_en_d;
    logic [WIDTH-1:0] op_dat_q, op_dat_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             uf_q, uf_d;
    logic             of_q, of_d;
    logic             ov_q, ov_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIDTH-1:0] col_q, col_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_we;
    logic [RW-1:0]    wr_idx;
    logic [RW-1:0]    rd_idx;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(DEPTH));
    assign wr_idx   = RW'(depth_q);
    assign rd_idx   = RW'(depth_q - DW'(1));

    always_comb begin
        state_d   = state_q;
        op_push_d = op_push_q;
        op_en_d   = op_en_q;
        op_dat_d  = op_dat_q;
        depth_d   = depth_q;
        uf_d      = uf_q;
        of_d      = of_q;
        ov_d      = 1'b0;
        row_d     = row_q;
        col_d     = col_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // Push wins when both are requested; the pop is simply dropped.
                if (push || pop) begin
                    state_d   = BUSY;
                    op_push_d = push;
                    op_en_d   = enable_output;
                    op_dat_d  = data_in;
                end
            end
            BUSY: begin
                state_d = IDLE;
                if (op_push_q) begin
                    if (is_full) begin
                        of_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        depth_d = depth_q + DW'(1);
                        uf_d    = 1'b0;
                    end
                end else if (is_empty) begin
                    uf_d = 1'b1;
                end else begin
                    depth_d = depth_q - DW'(1);
                    of_d    = 1'b0;
                    if (op_en_q) begin
                        ov_d  = 1'b1;
                        row_d = rd_idx;
                        col_d = mem[rd_idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_push_q <= 1'b0;
            op_en_q   <= 1'b0;
            op_dat_q  <= '0;
            depth_q   <= '0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            ov_q      <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_push_q <= op_push_d;
            op_en_q   <= op_en_d;
            op_dat_q  <= op_dat_d;
            depth_q   <= depth_d;
            uf_q      <= uf_d;
            of_q      <= of_d;
            ov_q      <= ov_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    // Storage is not cleared; entries at or above depth are never exposed.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[wr_idx] <= op_dat_q;
        end
    end

    assign top         = is_empty ? '0 : mem[rd_idx];
    assign depth       = depth_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign stack_ready = (state_q == IDLE);
    assign underflow   = uf_q;
    assign overflow    = of_q;
    assign out_valid   = ov_q;
    assign out_row     = row_q;
    assign out_column  = col_q;

endmodule

// File: tb/tb_queen_stack.sv
// Self-checking bench for queen_stack: constant vector table, directed corner sequences, random run vs queue model.
module tb_queen_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             reset, push, pop, enable_output;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] top;
    logic [3:0]       depth;
    logic             empty, full, stack_ready, underflow, overflow, out_valid;
    logic [2:0]       out_row;
    logic [WIDTH-1:0] out_column;

    queen_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .enable_output(enable_output), .data_in(data_in),
        .top(top), .depth(depth), .empty(empty), .full(full),
        .stack_ready(stack_ready), .underflow(underflow), .overflow(overflow),
        .out_valid(out_valid), .out_row(out_row), .out_column(out_column)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: a queue holds the stack, bottom at index 0.
    int mq[$];
    bit m_busy, m_push, m_en, m_uf, m_of, m_ov;
    int m_din, m_row, m_col;

    task automatic model_edge(input bit rst, input bit pu, input bit po, input bit en, input int din);
        int v;
        m_ov = 0;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_uf = 0; m_of = 0; m_row = 0; m_col = 0;
        end else if (m_busy) begin
            m_busy = 0;
            if (m_push) begin
                if (mq.size() == DEPTH) m_of = 1;
                else begin mq.push_back(m_din); m_uf = 0; end
            end else if (mq.size() == 0) begin
                m_uf = 1;
            end else begin
                v = mq.pop_back();
                m_of = 0;
                if (m_en) begin m_ov = 1; m_row = mq.size(); m_col = v; end
            end
        end else if (pu || po) begin
            m_busy = 1; m_push = pu; m_en = en; m_din = din;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".ready"}, int'(stack_ready), m_busy ? 0 : 1);
        chk({tag, ".depth"}, int'(depth), mq.size());
        chk({tag, ".top"}, int'(top), (mq.size() == 0) ? 0 : mq[mq.size()-1]);
        chk({tag, ".empty"}, int'(empty), (mq.size() == 0) ? 1 : 0);
        chk({tag, ".full"}, int'(full), (mq.size() == DEPTH) ? 1 : 0);
        chk({tag, ".underflow"}, int'(underflow), int'(m_uf));
        chk({tag, ".overflow"}, int'(overflow), int'(m_of));
        chk({tag, ".out_valid"}, int'(out_valid), int'(m_ov));
        chk({tag, ".out_row"}, int'(out_row), m_row);
        chk({tag, ".out_column"}, int'(out_column), m_col);
    endtask

    // Drive inputs, advance one edge, sample 1ns after it.
    task automatic step(input bit rst, input bit pu, input bit po, input bit en, input int din);
        reset = rst; push = pu; pop = po; enable_output = en; data_in = WIDTH'(din);
        model_edge(rst, pu, po, en, din);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst, pu, po, en;
        int din, rdy, dep, top, ful, uf, of, ov, row, col;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit pu, input bit po, input bit en, input int din,
                       input int rdy, input int dep, input int tp, input int ful,
                       input int uf, input int of, input int ov, input int row, input int col);
        vec_t v;
        v.rst = rst; v.pu = pu; v.po = po; v.en = en; v.din = din;
        v.rdy = rdy; v.dep = dep; v.top = tp; v.ful = ful;
        v.uf = uf; v.of = of; v.ov = ov; v.row = row; v.col = col;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; enable_output = 1'b0; data_in = '0;

        //   rst pu po en din | rdy dep top ful uf of ov row col
        add(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 5,   0, 1, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 2, 5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 7,   0, 2, 5, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 3, 7, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0,   0, 3, 7, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1,   1, 2, 5, 0, 0, 0, 1, 2, 7);   // push while BUSY is dropped
        add(0, 0, 0, 0, 0,   1, 2, 5, 0, 0, 0, 0, 2, 7);
        add(0, 1, 1, 1, 6,   0, 2, 5, 0, 0, 0, 0, 2, 7);   // push+pop -> push
        add(0, 0, 0, 0, 0,   1, 3, 6, 0, 0, 0, 0, 2, 7);
        add(0, 1, 0, 0, 4,   0, 3, 6, 0, 0, 0, 0, 2, 7);
        add(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);   // reset aborts BUSY push
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2,   0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);   // silent pop, out_* untouched
        add(1, 1, 0, 0, 5,   1, 0, 0, 0, 0, 0, 0, 0, 0);   // request during reset ignored
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].pu, tbl[i].po, tbl[i].en, tbl[i].din);
            chk({t, ".ready"}, int'(stack_ready), tbl[i].rdy);
            chk({t, ".depth"}, int'(depth), tbl[i].dep);
            chk({t, ".top"}, int'(top), tbl[i].top);
            chk({t, ".empty"}, int'(empty), (tbl[i].dep == 0) ? 1 : 0);
            chk({t, ".full"}, int'(full), tbl[i].ful);
            chk({t, ".underflow"}, int'(underflow), tbl[i].uf);
            chk({t, ".overflow"}, int'(overflow), tbl[i].of);
            chk({t, ".out_valid"}, int'(out_valid), tbl[i].ov);
            chk({t, ".out_row"}, int'(out_row), tbl[i].row);
            chk({t, ".out_column"}, int'(out_column), tbl[i].col);
        end

        // Fill to 8, then an overflowing push.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 0, 0, i);
            step(0, 0, 0, 0, 0);
        end
        chk("fill.full", int'(full), 1);
        chk("fill.depth", int'(depth), 8);
        chk("fill.top", int'(top), 7);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("ovf.overflow", int'(overflow), 1);
        chk("ovf.depth", int'(depth), 8);
        chk("ovf.top", int'(top), 7);
        cmp_model("ovf");
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovf_clr.overflow", int'(overflow), 0);
        chk("ovf_clr.depth", int'(depth), 7);
        step(0, 1, 0, 0, 7);
        step(0, 0, 0, 0, 0);
        chk("refill.top", int'(top), 7);

        // Drain with reporting: rows and columns come out 7..0.
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 0, 1, 1, 0);
            chk($sformatf("drain%0d.busy_ov", k), int'(out_valid), 0);
            step(0, 0, 0, 0, 0);
            chk($sformatf("drain%0d.out_valid", k), int'(out_valid), 1);
            chk($sformatf("drain%0d.out_row", k), int'(out_row), 7 - k);
            chk($sformatf("drain%0d.out_column", k), int'(out_column), 7 - k);
            chk($sformatf("drain%0d.depth", k), int'(depth), 7 - k);
        end
        step(0, 0, 0, 0, 0);
        chk("drain.pulse_end", int'(out_valid), 0);
        chk("drain.col_hold", int'(out_column), 0);

        // Pops on empty: underflow, no report, depth stays 0.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 1, 0);
            step(0, 0, 0, 0, 0);
            chk($sformatf("uf%0d.underflow", k), int'(underflow), 1);
            chk($sformatf("uf%0d.out_valid", k), int'(out_valid), 0);
            chk($sformatf("uf%0d.depth", k), int'(depth), 0);
        end
        step(0, 1, 0, 0, 4);
        step(0, 0, 0, 0, 0);
        chk("uf_clr.underflow", int'(underflow), 0);
        chk("uf_clr.top", int'(top), 4);
        cmp_model("uf_clr");

        // Random traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit rst, pu, po;
            r   = $urandom_range(0, 9);
            rst = ($urandom_range(0, 79) == 0);
            pu  = (r < 4);
            po  = (r >= 3 && r < 8);
            step(rst, pu, po, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
